// File: rtl/stack_pkg.sv
// Shared defaults, operation encoding and error-flag layout for the stack engine.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    // Encoding matches the {push, pop} strobe pair bit for bit
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_flags_t;

    function automatic op_e decode_op(input logic push, input logic pop);
        return op_e'({push, pop});
    endfunction

endpackage

// File: rtl/stack_mem.sv
// LIFO storage: DEPTH x WIDTH register array, one synchronous write port, one asynchronous read port.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_engine.sv
// Stack engine: pointer, A/B operand latch, zero flag and sticky error flags around stack_mem.
// Optional high-water-mark output hwm is enabled with the STACK_HWM_EN macro.
module stack_engine
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             sh_1,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] opnd_a,
    output logic [WIDTH-1:0] opnd_b,
    output logic [WIDTH-1:0] tos_data,
    output logic             zero,
    output logic [PTR_W-1:0] sp,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             udf_err
`ifdef STACK_HWM_EN
    ,
    output logic [PTR_W-1:0] hwm
`endif
);

    localparam int AW = $clog2(DEPTH);

    op_e              op;
    logic [PTR_W-1:0] sp_nxt;
    logic [PTR_W-1:0] sp_dec;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic             z_nxt;
    logic             we;
    logic             load;
    err_flags_t       err_q;
    err_flags_t       err_set;
    err_flags_t       err_nxt;

    assign op     = decode_op(push, pop);
    assign sp_dec = sp - PTR_W'(1);
    assign empty  = (sp == '0);
    assign full   = (sp == PTR_W'(DEPTH));

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (push_data),
        .raddr (sp_dec[AW-1:0]),
        .rdata (rd_data)
    );

    // Read index wraps to DEPTH-1 when empty, so the view is gated here
    assign tos_data = empty ? '0 : rd_data;

    always_comb begin
        sp_nxt  = sp;
        wr_ptr  = sp;
        we      = 1'b0;
        load    = 1'b0;
        err_set = '0;
        a_nxt   = opnd_a;
        b_nxt   = opnd_b;
        z_nxt   = zero;
        unique case (op)
            OP_PUSH: begin
                if (full) begin
                    err_set.ovf = 1'b1;
                end else begin
                    we     = 1'b1;
                    sp_nxt = sp + PTR_W'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    err_set.udf = 1'b1;
                end else begin
                    load   = 1'b1;
                    sp_nxt = sp_dec;
                end
            end
            OP_REPL: begin
                // Empty stack degrades to a plain push but still flags the pop
                if (empty) begin
                    err_set.udf = 1'b1;
                    we          = 1'b1;
                    sp_nxt      = sp + PTR_W'(1);
                end else begin
                    load   = 1'b1;
                    we     = 1'b1;
                    wr_ptr = sp_dec;
                end
            end
            default: ;
        endcase
        if (load) begin
            a_nxt = rd_data;
            z_nxt = (rd_data == '0);
            if (sh_1) begin
                b_nxt = opnd_a;
            end
        end
        err_nxt.ovf = (err_q.ovf & ~clr_err) | err_set.ovf;
        err_nxt.udf = (err_q.udf & ~clr_err) | err_set.udf;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp     <= '0;
            opnd_a <= '0;
            opnd_b <= '0;
            zero   <= 1'b0;
            err_q  <= '0;
        end else begin
            sp     <= sp_nxt;
            opnd_a <= a_nxt;
            opnd_b <= b_nxt;
            zero   <= z_nxt;
            err_q  <= err_nxt;
        end
    end

    assign ovf_err = err_q.ovf;
    assign udf_err = err_q.udf;

`ifdef STACK_HWM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hwm <= '0;
        end else if (clr_err) begin
            hwm <= '0;
        end else if (sp_nxt > hwm) begin
            hwm <= sp_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Scoreboard bench for stack_engine: queue-based LIFO reference model, directed scenarios plus random traffic.
module tb_stack_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, sh_1, clr_err;
    logic [7:0] push_data;
    logic [7:0] opnd_a, opnd_b, tos_data;
    logic       zero, empty, full, ovf_err, udf_err;
    logic [4:0] sp;
`ifdef STACK_HWM_EN
    logic [4:0] hwm;
`endif

    stack_engine dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .sh_1      (sh_1),
        .push_data (push_data),
        .clr_err   (clr_err),
        .opnd_a    (opnd_a),
        .opnd_b    (opnd_b),
        .tos_data  (tos_data),
        .zero      (zero),
        .sp        (sp),
        .empty     (empty),
        .full      (full),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
`ifdef STACK_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, tos;
        logic       z, e, f, o, u;
        logic [4:0] sp;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference model state
    logic [7:0] m_stk[$];
    logic [7:0] m_a, m_b;
    logic       m_z, m_ovf, m_udf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_a = '0; m_b = '0; m_z = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic model_load(input logic [7:0] w, input logic s);
        if (s) m_b = m_a;
        m_a = w;
        m_z = (w == 8'h00);
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.a   = m_a;
        e.b   = m_b;
        e.z   = m_z;
        e.sp  = 5'(m_stk.size());
        e.e   = (m_stk.size() == 0);
        e.f   = (m_stk.size() == 16);
        e.o   = m_ovf;
        e.u   = m_udf;
        e.tos = (m_stk.size() == 0) ? 8'h00 : m_stk[$];
        return e;
    endfunction

    task automatic model_step(input logic p, input logic po, input logic s,
                              input logic [7:0] d, input logic c);
        logic ovf_new, udf_new;
        logic [7:0] top;
        ovf_new = 1'b0;
        udf_new = 1'b0;
        if (p && po) begin
            if (m_stk.size() == 0) begin
                m_stk.push_back(d);
                udf_new = 1'b1;
            end else begin
                top = m_stk.pop_back();
                model_load(top, s);
                m_stk.push_back(d);
            end
        end else if (p) begin
            if (m_stk.size() == 16) ovf_new = 1'b1;
            else m_stk.push_back(d);
        end else if (po) begin
            if (m_stk.size() == 0) udf_new = 1'b1;
            else begin
                top = m_stk.pop_back();
                model_load(top, s);
            end
        end
        m_ovf = (m_ovf && !c) || ovf_new;
        m_udf = (m_udf && !c) || udf_new;
    endtask

    // Drive one cycle; the expectation enters the scoreboard once the edge that applies it has passed
    task automatic do_op(input logic p, input logic po, input logic s,
                         input logic [7:0] d, input logic c);
        exp_t e;
        push = p; pop = po; sh_1 = s; push_data = d; clr_err = c;
        model_step(p, po, s, d, c);
        e = model_snapshot();
        @(posedge clk);
        sb.push_back(e);
        #1;
        push = 1'b0; pop = 1'b0; sh_1 = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sp"},     32'(sp),      32'd0);
        chk({tag, "_opnd_a"}, 32'(opnd_a),  32'd0);
        chk({tag, "_opnd_b"}, 32'(opnd_b),  32'd0);
        chk({tag, "_zero"},   32'(zero),    32'd0);
        chk({tag, "_empty"},  32'(empty),   32'd1);
        chk({tag, "_ovf"},    32'(ovf_err), 32'd0);
        chk({tag, "_udf"},    32'(udf_err), 32'd0);
        chk({tag, "_tos"},    32'(tos_data), 32'd0);
    endtask

    // Monitor: every cycle is an output presentation, compared on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("opnd_a",   32'(opnd_a),   32'(e.a));
                chk("opnd_b",   32'(opnd_b),   32'(e.b));
                chk("zero",     32'(zero),     32'(e.z));
                chk("sp",       32'(sp),       32'(e.sp));
                chk("empty",    32'(empty),    32'(e.e));
                chk("full",     32'(full),     32'(e.f));
                chk("ovf_err",  32'(ovf_err),  32'(e.o));
                chk("udf_err",  32'(udf_err),  32'(e.u));
                chk("tos_data", 32'(tos_data), 32'(e.tos));
            end
        end
    end

    initial begin
        rst = 1'b0;
        push = 1'b0; pop = 1'b0; sh_1 = 1'b0; clr_err = 1'b0; push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // Two pushes, pop, pop with shift: A=0x05, B=0x03
        do_op(1, 0, 0, 8'h05, 0);
        do_op(1, 0, 0, 8'h03, 0);
        do_op(0, 1, 0, 8'h00, 0);
        do_op(0, 1, 1, 8'h00, 0);
        do_op(0, 0, 1, 8'h00, 0);

        // Zero flag on a popped zero, then cleared by a non-zero pop
        do_op(1, 0, 0, 8'h00, 0);
        do_op(0, 1, 0, 8'h00, 0);
        do_op(1, 0, 0, 8'h07, 0);
        do_op(0, 1, 0, 8'h00, 0);

        // Fill, overflow, clear
        for (int i = 0; i < 16; i++) do_op(1, 0, 0, 8'(8'h10 + i), 0);
        do_op(1, 0, 0, 8'hAA, 0);
        do_op(0, 0, 0, 8'h00, 0);
        do_op(0, 0, 0, 8'h00, 1);
        // Replace at full is legal
        do_op(1, 1, 1, 8'h99, 0);

        // Drain, then underflow on empty
        for (int i = 0; i < 16; i++) do_op(0, 1, i[0], 8'h00, 0);
        do_op(0, 1, 1, 8'h00, 0);
        do_op(0, 1, 0, 8'h00, 0);
        // Replace on empty degrades to push with underflow
        do_op(1, 1, 0, 8'h44, 1);
        do_op(0, 1, 0, 8'h00, 1);

        // Replace top
        do_op(1, 0, 0, 8'h11, 0);
        do_op(1, 0, 0, 8'h22, 0);
        do_op(1, 1, 0, 8'h33, 0);
        do_op(0, 0, 0, 8'h00, 0);

        // Random traffic, push-heavy then pop-heavy, with occasional clr_err
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            if (i < 300) begin
                if (r < 5)       do_op(1, 0, 1'($urandom), d, 0);
                else if (r < 7)  do_op(0, 1, 1'($urandom), d, 0);
                else if (r < 8)  do_op(1, 1, 1'($urandom), d, 0);
                else if (r < 9)  do_op(0, 0, 1'($urandom), d, 0);
                else             do_op(1'($urandom), 1'($urandom), 1'($urandom), d, 1);
            end else begin
                if (r < 2)       do_op(1, 0, 1'($urandom), d, 0);
                else if (r < 6)  do_op(0, 1, 1'($urandom), d, 0);
                else if (r < 7)  do_op(1, 1, 1'($urandom), d, 0);
                else if (r < 9)  do_op(0, 0, 1'($urandom), d, 0);
                else             do_op(1'($urandom), 1'($urandom), 1'($urandom), d, 1);
            end
        end

        // Mid-cycle asynchronous reset with a populated stack and an error flag set
        do_op(0, 0, 0, 8'h00, 1);
        while (m_stk.size() != 0) do_op(0, 1, 0, 8'h00, 0);
        do_op(0, 1, 0, 8'h00, 1);
        do_op(1, 0, 0, 8'h01, 0);
        do_op(1, 0, 0, 8'h02, 0);
        do_op(1, 0, 0, 8'h03, 0);
        do_op(1, 0, 0, 8'h04, 0);
        do_op(0, 1, 1, 8'h00, 0);
        do_op(1, 0, 0, 8'h05, 0);
        do_op(0, 1, 0, 8'h00, 0);
        do_op(0, 1, 0, 8'h00, 0);
        do_op(1, 0, 0, 8'h06, 0);
        do_op(1, 0, 0, 8'h07, 0);
`ifdef STACK_HWM_EN
        #1;
        chk("hwm_before_reset", 32'(hwm), 32'd4);
`endif
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_reset_state("async_reset");
`ifdef STACK_HWM_EN
        chk("hwm_after_reset", 32'(hwm), 32'd0);
`endif
        #1;
        rst = 1'b1;
        do_op(1, 0, 0, 8'h5A, 0);
        do_op(0, 1, 0, 8'h00, 0);
        do_op(0, 0, 0, 8'h00, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Responder side of the stack-machine control interface: executes the push / pop / sh_1 strobes issued by the multicycle controller.
- Holds the LIFO storage, stack pointer, two-operand latch (A/B) feeding the ALU, and the zero flag consumed by JZ.
- Sits in the datapath between the controller, ALU and data memory; one operation per cycle, no stall.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH)+1, stack-pointer width (extra bit encodes full).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  push strobe, one word per asserted cycle.
- pop  in  1  pop strobe, one word per asserted cycle.
- sh_1  in  1  qualifies pop: shift A into B before loading A.
- push_data  in  WIDTH  word to push.
- clr_err  in  1  synchronous clear of sticky error flags.
- opnd_a  out  WIDTH  most recently popped word (ALU operand A).
- opnd_b  out  WIDTH  previously popped word (ALU operand B).
- tos_data  out  WIDTH  combinational view of mem[sp-1]; 0 when empty.
- zero  out  1  registered: last popped word == 0.
- sp  out  PTR_W  entry count / next write index.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- ovf_err  out  1  sticky: push attempted while full.
- udf_err  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst low, async): sp=0, opnd_a=0, opnd_b=0, zero=0, ovf_err=0, udf_err=0. Storage contents are not reset; reads of unwritten entries are not relied on.
- Push only, not full: mem[sp] <= push_data; sp <= sp+1. The word is visible on tos_data the next cycle.
- Pop only, not empty, sh_1=0: opnd_a <= mem[sp-1]; sp <= sp-1; zero <= (mem[sp-1]==0); opnd_b holds.
- Pop with sh_1=1, not empty: opnd_b <= opnd_a; opnd_a <= mem[sp-1]; sp and zero update as above. Pop-then-pop(sh_1) yields A=second-from-top, B=old top.
- Latency: popped data and zero valid one cycle after the pop strobe.
- sh_1 without pop: ignored.
- Push and pop in the same cycle, not empty: replace top. opnd_a/zero load the old mem[sp-1] (sh_1 honoured); mem[sp-1] <= push_data; sp unchanged.
- Push and pop in the same cycle, empty: treat as push only; udf_err <= 1.
- Push while full (without pop): storage and sp unchanged; ovf_err <= 1.
- Pop while empty: sp, opnd_a, opnd_b and zero unchanged; udf_err <= 1.
- Error flags stay set until clr_err. If clr_err and a new error occur in the same cycle, the flag remains set.
- sp arithmetic is unsigned and never wraps; full/empty are decoded from sp.
- Reset asserted mid-operation aborts the operation; the stack is logically empty afterwards.

Optional Feature:
- Macro STACK_HWM_EN.
- Defined: adds output hwm [PTR_W]. hwm is reset to 0, updated to max(hwm, next sp) each cycle, and cleared by clr_err.
- Undefined: port and register are absent; all other behaviour is identical.

Decomposition:
- Package stack_pkg: WIDTH/DEPTH defaults, an op encoding enum {OP_NONE, OP_PUSH, OP_POP, OP_REPL} derived from {push, pop}, and an error-flag struct.
- One sub-module, stack_mem: DEPTH x WIDTH register array with one synchronous write port and one asynchronous read port at sp-1. Pointer, operand latch and flag logic stay in stack_engine.

Test Plan:
- Reset, push 0x05, push 0x03, pop, pop+sh_1 -> opnd_a=0x05, opnd_b=0x03, sp=0, empty=1, zero=0.
- Push 0x00, pop -> next cycle zero=1 and opnd_a=0x00. Then push 0x07, pop -> zero=0.
- Push 16 words 0x10..0x1F -> full=1, sp=16. A 17th push of 0xAA -> ovf_err=1, sp=16, tos_data=0x1F. Then clr_err -> ovf_err=0.
- Pop on empty -> udf_err=1; opnd_a, opnd_b and sp unchanged.
- Push 0x11, push 0x22, then same-cycle push 0x33 + pop -> opnd_a=0x22, tos_data=0x33, sp=2.
- Push 4 words, assert rst low mid-cycle -> sp=0, opnd_a=0, flags=0 immediately, without waiting for a clock edge. With STACK_HWM_EN, hwm=4 before reset and 0 after.
